// File: rtl/tcp_listen_port_mgr.sv
// tcp_listen_port_mgr: opens NUM_PORTS consecutive TCP listen ports starting at
// BASE_PORT. Each port gets its own retry budget, and a fixed wait interval
// separates the attempts.
// Optional build macro LISTEN_STATUS_TIMEOUT_EN: when it is defined, a STATUS
// phase that receives no status beat for 2^RETRY_INTERVAL_LOG2 cycles counts as
// a failed attempt. When it is not defined, STATUS waits for a beat forever.
module tcp_listen_port_mgr #(
  parameter int unsigned NUM_PORTS           = 1,
  parameter logic [15:0] BASE_PORT           = 16'h0B48,
  parameter int unsigned RETRY_INTERVAL_LOG2 = 15,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  logic                 aclk,
  input  logic                 rst,
  output logic                 m_axis_listen_port_TVALID,
  input  logic                 m_axis_listen_port_TREADY,
  output logic [15:0]          m_axis_listen_port_TDATA,
  input  logic                 s_axis_listen_port_status_TVALID,
  output logic                 s_axis_listen_port_status_TREADY,
  input  logic [7:0]           s_axis_listen_port_status_TDATA,
  output logic [NUM_PORTS-1:0] ports_open,
  output logic                 all_open,
  output logic                 error
);

  localparam int unsigned IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned CNT_W = RETRY_INTERVAL_LOG2;
  localparam int unsigned RTY_W = 4;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PORTS - 1);
  localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRIES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_REQ    = 3'd1,
    S_STATUS = 3'd2,
    S_DONE   = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [RTY_W-1:0]     r_retry;
  logic [RTY_W-1:0]     w_retry_nxt;
  logic [RTY_W-1:0]     w_retry_inc;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [NUM_PORTS-1:0] r_open;
  logic [NUM_PORTS-1:0] w_open_nxt;
  logic                 w_fail;
  logic                 r_tvalid;
  logic [15:0]          r_tdata;
  logic                 r_all_open;
  logic                 r_error;
  logic                 w_unused;

  // Only bit 0 of a status beat matters; the remaining bits are folded here and dropped.
  assign w_unused = ^s_axis_listen_port_status_TDATA[7:1];

  assign m_axis_listen_port_TVALID        = r_tvalid;
  assign m_axis_listen_port_TDATA         = r_tdata;
  assign s_axis_listen_port_status_TREADY = 1'b1;
  assign ports_open                       = r_open;
  assign all_open                         = r_all_open;
  assign error                            = r_error;

  // State register.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_state <= S_WAIT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus the next values of the port index, retry count, interval counter and open mask.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_retry_nxt = r_retry;
    w_cnt_nxt   = r_cnt;
    w_open_nxt  = r_open;
    w_fail      = 1'b0;
    w_retry_inc = r_retry + RTY_W'(1);

    case (r_state)
      S_WAIT: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_MAX) begin
          w_state_nxt = S_REQ;
        end
      end

      S_REQ: begin
        if (m_axis_listen_port_TREADY) begin
          w_state_nxt = S_STATUS;
`ifdef LISTEN_STATUS_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end

      S_STATUS: begin
        if (s_axis_listen_port_status_TVALID) begin
          if (s_axis_listen_port_status_TDATA[0]) begin
            w_open_nxt[r_idx] = 1'b1;
            w_retry_nxt       = '0;
            if (r_idx == LAST_IDX) begin
              w_state_nxt = S_DONE;
            end else begin
              w_idx_nxt   = r_idx + IDX_W'(1);
              w_state_nxt = S_REQ;
            end
          end else begin
            w_fail = 1'b1;
          end
        end
`ifdef LISTEN_STATUS_TIMEOUT_EN
        else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_MAX) begin
            w_fail = 1'b1;
          end
        end
`endif
        if (w_fail) begin
          w_retry_nxt = w_retry_inc;
          w_cnt_nxt   = '0;
          w_state_nxt = (w_retry_inc == RTY_LIMIT) ? S_FAIL : S_WAIT;
        end
      end

      S_DONE: begin
        w_state_nxt = S_DONE;
      end

      S_FAIL: begin
        w_state_nxt = S_FAIL;
      end

      default: begin
        w_state_nxt = S_WAIT;
      end
    endcase
  end

  // Datapath registers. The outputs are registered from the next state, so TVALID is high exactly while in REQ.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      r_idx      <= '0;
      r_retry    <= '0;
      r_cnt      <= '0;
      r_open     <= '0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_all_open <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_idx      <= w_idx_nxt;
      r_retry    <= w_retry_nxt;
      r_cnt      <= w_cnt_nxt;
      r_open     <= w_open_nxt;
      r_tvalid   <= (w_state_nxt == S_REQ);
      r_tdata    <= (w_state_nxt == S_REQ) ? (BASE_PORT + 16'(w_idx_nxt)) : 16'h0000;
      r_all_open <= (w_state_nxt == S_DONE);
      r_error    <= (w_state_nxt == S_FAIL);
    end
  end

endmodule

// File: tb/tb_tcp_listen_port_mgr.sv
// Scoreboard bench for tcp_listen_port_mgr with NUM_PORTS=2, 16-cycle interval and MAX_RETRIES=2.
// The stimulus pushes each expected request (port, cycle); the monitor pops one entry per handshake and checks it.
module tb_tcp_listen_port_mgr;

  logic        aclk;
  logic        rst;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] m_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [7:0]  s_tdata;
  logic [1:0]  ports_open;
  logic        all_open;
  logic        error;

  int checks   = 0;
  int failures = 0;
  int cyc;

  typedef struct {
    logic [15:0] port;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  tcp_listen_port_mgr #(
    .NUM_PORTS           (2),
    .BASE_PORT           (16'h0B48),
    .RETRY_INTERVAL_LOG2 (4),
    .MAX_RETRIES         (2)
  ) dut (
    .aclk                             (aclk),
    .rst                              (rst),
    .m_axis_listen_port_TVALID        (m_tvalid),
    .m_axis_listen_port_TREADY        (m_tready),
    .m_axis_listen_port_TDATA         (m_tdata),
    .s_axis_listen_port_status_TVALID (s_tvalid),
    .s_axis_listen_port_status_TREADY (s_tready),
    .s_axis_listen_port_status_TDATA  (s_tdata),
    .ports_open                       (ports_open),
    .all_open                         (all_open),
    .error                            (error)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Counts rising edges since reset was released.
  always @(posedge aclk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t cyc=%0d)", name, act, exp, $time, cyc);
    end
  endtask

  task automatic push(input logic [15:0] p, input int c);
    exp_t e;
    e.port = p;
    e.cyc  = c;
    q.push_back(e);
  endtask

  // Moves to just after rising edge n; inputs driven here are sampled at edge n+1.
  task automatic at_cyc(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 5000) begin
      @(posedge aclk);
      #1;
      g++;
    end
    if (cyc != n) begin
      failures++;
      $display("FAIL at_cyc: actual=%0d required=%0d", cyc, n);
    end
  endtask

  task automatic beat(input logic [7:0] d);
    s_tvalid = 1'b1;
    s_tdata  = d;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, then releases reset just after a rising edge.
  task automatic do_reset(input logic rdy);
    chk("leftover_expected_req", q.size(), 0);
    rst      = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_ports_open", ports_open, 0);
    chk("rst_all_open", all_open, 0);
    chk("rst_error", error, 0);
    chk("status_tready", s_tready, 1);
    q.delete();
    repeat (3) @(posedge aclk);
    #1;
    m_tready = rdy;
    rst      = 1'b0;
  endtask

  // Monitor: every request handshake must match the next expected entry.
  always @(negedge aclk) begin
    if (!rst && m_tvalid && m_tready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_req: actual=0x%0h required=none (cyc=%0d)", m_tdata, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("req_port", m_tdata, mon_e.port);
        chk("req_cycle", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    rst      = 1'b1;
    m_tready = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = 8'h00;
    #2;

    // Two clean opens, with status beats sent during WAIT and on the handshake cycle that must be ignored.
    do_reset(1'b1);
    push(16'h0B48, 16);
    push(16'h0B49, 18);
    at_cyc(4);  beat(8'h00);
    at_cyc(5);  s_tvalid = 1'b0;
    at_cyc(15); beat(8'h00);
    at_cyc(17); beat(8'h01);
    at_cyc(18);
    chk("s1_open_mid", ports_open, 2'b01);
    chk("s1_all_open_mid", all_open, 0);
    beat(8'h00);
    at_cyc(19); beat(8'h01);
    at_cyc(20); s_tvalid = 1'b0;
    at_cyc(22);
    chk("s1_ports_open", ports_open, 2'b11);
    chk("s1_all_open", all_open, 1);
    chk("s1_error", error, 0);
    chk("s1_done_tvalid", m_tvalid, 0);

    // Backpressure: the request holds steady for 5 cycles, then reset lands while the next request is valid.
    do_reset(1'b0);
    for (int k = 16; k <= 20; k++) begin
      at_cyc(k);
      chk("s2_hold_tvalid", m_tvalid, 1);
      chk("s2_hold_tdata", m_tdata, 16'h0B48);
    end
    push(16'h0B48, 20);
    m_tready = 1'b1;
    at_cyc(21);
    chk("s2_tvalid_drop", m_tvalid, 0);
    m_tready = 1'b0;
    beat(8'h01);
    at_cyc(22); s_tvalid = 1'b0;
    at_cyc(23);
    chk("s2_port1_tvalid", m_tvalid, 1);
    chk("s2_port1_tdata", m_tdata, 16'h0B49);

    // One failure, a full WAIT, then a successful retry of the same port.
    do_reset(1'b1);
    push(16'h0B48, 16);
    push(16'h0B48, 34);
    push(16'h0B49, 36);
    at_cyc(17); beat(8'h00);
    at_cyc(18); s_tvalid = 1'b0;
    at_cyc(30);
    chk("s3_wait_error", error, 0);
    chk("s3_wait_tvalid", m_tvalid, 0);
    chk("s3_wait_open", ports_open, 0);
    at_cyc(35); beat(8'h01);
    at_cyc(36); s_tvalid = 1'b0;
    at_cyc(38);
    chk("s3_ports_open", ports_open, 2'b01);
    chk("s3_error", error, 0);

    // Two failures on port 0: terminal FAIL, and the request line stays quiet afterwards.
    do_reset(1'b1);
    push(16'h0B48, 16);
    push(16'h0B48, 34);
    at_cyc(17); beat(8'h00);
    at_cyc(18); s_tvalid = 1'b0;
    at_cyc(35); beat(8'h00);
    at_cyc(36); s_tvalid = 1'b0;
    at_cyc(37);
    chk("s4_error", error, 1);
    chk("s4_ports_open", ports_open, 0);
    chk("s4_all_open", all_open, 0);
    hi = 0;
    repeat (1000) begin
      @(posedge aclk);
      #1;
      if (m_tvalid) hi++;
    end
    chk("s4_quiet_tvalid_cycles", hi, 0);
    chk("s4_error_sticky", error, 1);

    // No status at all after the first request.
    do_reset(1'b1);
    push(16'h0B48, 16);
`ifdef LISTEN_STATUS_TIMEOUT_EN
    push(16'h0B48, 49);
    at_cyc(70);
    chk("s5_timeout_error", error, 1);
    chk("s5_timeout_open", ports_open, 0);
`else
    at_cyc(200);
    chk("s5_no_timeout_error", error, 0);
    chk("s5_no_timeout_tvalid", m_tvalid, 0);
    chk("s5_no_timeout_all_open", all_open, 0);
    chk("s5_no_timeout_open", ports_open, 0);
`endif

    // Reset during STATUS of port 1 discards progress; the sequence restarts at port 0.
    do_reset(1'b1);
    push(16'h0B48, 16);
    push(16'h0B49, 18);
    at_cyc(17); beat(8'h01);
    at_cyc(18); s_tvalid = 1'b0;
    at_cyc(21);
    chk("s6_open_before_rst", ports_open, 2'b01);
    do_reset(1'b1);
    push(16'h0B48, 16);
    at_cyc(17);
    chk("s6_restart_open", ports_open, 0);
    chk("s6_restart_tvalid", m_tvalid, 0);
    at_cyc(20);
    chk("s6_restart_req_seen", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcp_listen_port_mgr.md
TCP_LISTEN_PORT_MGR -- requirements
Module: tcp_listen_port_mgr

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 1: number of consecutive listen ports to open, legal range 1..16.
REQ-002 SHALL have parameter BASE_PORT, default 16'h0B48: first port number (2888); port k is BASE_PORT+k.
REQ-003 SHALL have parameter RETRY_INTERVAL_LOG2, default 15: wait interval is 2^RETRY_INTERVAL_LOG2 cycles, legal range 2..24.
REQ-004 SHALL have parameter MAX_RETRIES, default 4: failed attempts allowed per port before a hard error, legal range 1..15.
REQ-005 SHALL use one clock, aclk; reset is asynchronous and active-high, named rst.
REQ-006 aclk  in  1  sole clock; all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 m_axis_listen_port_TVALID  out  1  listen request valid.
REQ-009 m_axis_listen_port_TREADY  in  1  TCP stack accepts the request.
REQ-010 m_axis_listen_port_TDATA  out  16  port number requested.
REQ-011 s_axis_listen_port_status_TVALID  in  1  status valid.
REQ-012 s_axis_listen_port_status_TREADY  out  1  tied to 1.
REQ-013 s_axis_listen_port_status_TDATA  in  8  bit0=1 means success; bits 7:1 are ignored.
REQ-014 ports_open  out  NUM_PORTS  bit k=1 once port k is confirmed open.
REQ-015 all_open  out  1  high when all ports are open (DONE state).
REQ-016 error  out  1  sticky high once a port exhausts its retries (FAIL state).

Function
REQ-017 SHALL implement states WAIT, REQ, STATUS, DONE, FAIL.
REQ-018 WAIT: interval counter counts 2^RETRY_INTERVAL_LOG2 cycles, then goes to REQ; counter is cleared on WAIT entry.
REQ-019 REQ: TVALID=1 with TDATA=BASE_PORT+idx, held stable until TREADY=1; the handshake cycle moves to STATUS and TVALID falls next cycle.
REQ-020 STATUS: first status beat with TDATA[0]=1 sets ports_open[idx] and clears the retry count.
REQ-021 After a success, if idx==NUM_PORTS-1 go to DONE, else idx increments and the next REQ issues immediately, with no WAIT.
REQ-022 STATUS: a beat with TDATA[0]=0 is a failure; retry count increments.
REQ-023 After a failure, if the count reaches MAX_RETRIES go to FAIL, else go to WAIT and retry the same idx.
REQ-024 Status beats arriving in WAIT, REQ, DONE or FAIL SHALL be accepted and discarded without state effect.
REQ-025 Status TVALID on the same cycle as the request handshake is ignored; only beats from the following cycle count.
REQ-026 Port arithmetic SHALL be 16-bit modulo; BASE_PORT+idx wraps past 16'hFFFF.
REQ-027 DONE and FAIL are terminal until reset; TVALID stays 0 in both.
REQ-028 all_open and error are registered, asserted the cycle after entering DONE or FAIL, and never both high.

Reset
REQ-029 On rst=1, all outputs SHALL go to 0 asynchronously: TVALID=0, TDATA=0, ports_open=0, all_open=0, error=0.
REQ-030 On rst=1, state SHALL go to WAIT with idx=0, retry count 0 and interval counter 0; the first request follows a full interval after release.
REQ-031 Reset asserted mid-handshake (TVALID=1) SHALL drop TVALID immediately; any partial progress is discarded.

Configuration
REQ-032 Macro LISTEN_STATUS_TIMEOUT_EN SHALL control the STATUS-state timeout.
REQ-033 With LISTEN_STATUS_TIMEOUT_EN defined, STATUS with no beat for 2^RETRY_INTERVAL_LOG2 cycles counts as a failure per REQ-022/023.
REQ-034 Without LISTEN_STATUS_TIMEOUT_EN, STATUS waits indefinitely, and no timeout counter logic is synthesised.

Verification (NUM_PORTS=2, RETRY_INTERVAL_LOG2=4, MAX_RETRIES=2)
REQ-035 Reset release, TREADY=1, status 8'h01 twice: requests 16'h0B48 at cycle 16, then 16'h0B49; ports_open=2'b11, all_open=1.
REQ-036 TREADY=0 for 5 cycles in REQ: TVALID and TDATA=16'h0B48 stay stable for all 5 cycles; exactly one handshake occurs.
REQ-037 Status 8'h00 then 8'h01 on port 0: 16 cycles of WAIT, then a second 16'h0B48 request; ports_open[0]=1, error=0.
REQ-038 Status 8'h00 twice on port 0: FAIL, error=1, ports_open=0, and no further TVALID for 1000 cycles.
REQ-039 Timeout build, no status after the first request: retry after 16+16 cycles; FAIL after the second timeout. Non-timeout build: stays in STATUS.
REQ-040 rst pulsed during STATUS of port 1: outputs clear at once; the sequence restarts at 16'h0B48 after 16 cycles.
